// File: rtl/cpu_divider.sv
// ============================================================================
// Module  : cpu_divider
// Brief   : Radix-2 restoring DIV/DIVU unit producing LO (quotient) and HI
//           (remainder), one quotient bit per clock, with pipeline stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  // Partial remainder can reach WIDTH+1 bits after the shift, so compare wide.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign take     = (shifted >= {1'b0, dvs});
  assign rem_next = take ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];

  assign dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  assign busy_o  = (state == DIVIDE) || (state == FIXUP);
  assign done_o  = (state == DONE);
  assign stall_o = busy_o || (start_i && (state == IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            neg_q    <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_r    <= signed_i && dividend_i[WIDTH-1];
            div_zero <= (divisor_i == '0);
            quo      <= dividend_mag;
            dvs      <= divisor_mag;
            rem      <= '0;
            count    <= CW'(WIDTH - 1);
            state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], take};
            if (count == '0) state <= FIXUP;
            else             count <= count - 1'b1;
          end
        end
        FIXUP: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            // Divide by zero leaves |dividend| in rem, so re-signing restores the raw dividend.
            quotient_o  <= div_zero ? '1 : (neg_q ? -quo : quo);
            remainder_o <= neg_r ? -rem : rem;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
